// File: rtl/ir_err_calc_pkg.sv
// Shared types and constants for the IR line-sensor error calculator.
package ir_pkg;

    localparam int RES_W  = 12;   // A2D result width
    localparam int ACC_W  = 18;   // signed weighted accumulator width
    localparam int ERR_W  = 16;   // saturated error width
    localparam int NUM_CH = 8;    // number of line sensors

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CNV,
        WAIT,
        DONE
    } state_t;

    // Channel weights: ch0 side positive, ch7 side negative.
    localparam logic signed [4:0] WEIGHT [NUM_CH] = '{
        5'sd8, 5'sd4, 5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd4, -5'sd8
    };

    localparam logic signed [ACC_W-1:0] ERR_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] ERR_MIN = -18'sd32768;

    // Clamp the wide accumulator into the 16-bit signed error range.
    function automatic logic [ERR_W-1:0] sat_err(input logic signed [ACC_W-1:0] a);
        if (a > ERR_MAX) begin
            return 16'h7FFF;
        end else if (a < ERR_MIN) begin
            return 16'h8000;
        end else begin
            return a[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ir_err_calc_if.sv
// A2D handshake plus the error result bus consumed by the PID stage.
interface ir_err_calc_if;
    import ir_pkg::*;

    logic              strt_cnv;
    logic [2:0]        chnnl;
    logic              cnv_cmplt;
    logic [RES_W-1:0]  res;
    logic [ERR_W-1:0]  error;
    logic              err_vld;
    logic              line_present;

    // The error calculator drives conversion requests and the result.
    modport master (
        output strt_cnv, chnnl, error, err_vld, line_present,
        input  cnv_cmplt, res
    );

    // The A2D converter / result consumer side.
    modport slave (
        input  strt_cnv, chnnl, error, err_vld, line_present,
        output cnv_cmplt, res
    );
endinterface

// File: rtl/ir_err_calc_period_timer.sv
// Free-running sample-period counter; tick marks the wrap back to 0.
module ir_period_timer #(
    parameter int PERIOD   = 50000,
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int PER_EFF = FAST_SIM ? 2048 : PERIOD;
    localparam int CW      = $clog2(PER_EFF);
    localparam logic [CW-1:0] LAST = CW'(PER_EFF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count: held at 0 while disabled, wraps at the end of the period.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/ir_err_calc.sv
// Sequences IR emitters and 8 A2D conversions, producing a weighted steering error.
module ir_err_calc
    import ir_pkg::*;
#(
    parameter bit          FAST_SIM   = 1'b0,
    parameter int          PERIOD     = 50000,
    parameter int          SETTLE_CYC = 1024,
    parameter logic [15:0] LINE_THRES = 16'h0400,
    parameter int          TIMEOUT    = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    ir_err_calc_if.master bus,
    output logic          IR_en,
    output logic          a2d_fault
);
    localparam int SETTLE_EFF = FAST_SIM ? 64 : SETTLE_CYC;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_EFF - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);

    logic tick;

    ir_period_timer #(
        .PERIOD   (PERIOD),
        .FAST_SIM (FAST_SIM)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    state_t                  state_q, state_d;
    logic [15:0]             settle_q, settle_d;
    logic [15:0]             tmo_q, tmo_d;
    logic [2:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             sum_q, sum_d;
    logic                    ir_en_q, ir_en_d;
    logic                    strt_q, strt_d;
    logic                    fault_q, fault_d;
    logic                    vld_q, vld_d;
    logic [ERR_W-1:0]        error_q, error_d;
    logic                    lp_q, lp_d;

    logic signed [ACC_W-1:0] w_ext, res_ext, prod;

    // Weighted contribution of the current channel's reading.
    always_comb begin
        w_ext   = ACC_W'(WEIGHT[idx_q]);
        res_ext = $signed(ACC_W'(bus.res));
        prod    = w_ext * res_ext;
    end

    // Sample-cycle sequencing; en low overrides everything, including a final cnv_cmplt.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        ir_en_d  = ir_en_q;
        error_d  = error_q;
        lp_d     = lp_q;
        strt_d   = 1'b0;
        fault_d  = 1'b0;
        vld_d    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            ir_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        acc_d    = '0;
                        sum_d    = '0;
                        idx_d    = '0;
                        settle_d = '0;
                        ir_en_d  = 1'b1;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        strt_d  = 1'b1;
                        state_d = CNV;
                    end else begin
                        settle_d = settle_q + 16'd1;
                    end
                end
                CNV: begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.cnv_cmplt) begin
                        acc_d = acc_q + prod;
                        sum_d = sum_q + 16'(bus.res);
                        if (idx_q == 3'd7) begin
                            ir_en_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            strt_d  = 1'b1;
                            state_d = CNV;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        fault_d = 1'b1;
                        ir_en_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                DONE: begin
                    error_d = sat_err(acc_q);
                    lp_d    = (sum_q > LINE_THRES);
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            ir_en_q  <= 1'b0;
            strt_q   <= 1'b0;
            fault_q  <= 1'b0;
            vld_q    <= 1'b0;
            error_q  <= '0;
            lp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            ir_en_q  <= ir_en_d;
            strt_q   <= strt_d;
            fault_q  <= fault_d;
            vld_q    <= vld_d;
            error_q  <= error_d;
            lp_q     <= lp_d;
        end
    end

    assign bus.strt_cnv     = strt_q;
    assign bus.chnnl        = idx_q;
    assign bus.error        = error_q;
    assign bus.err_vld      = vld_q;
    assign bus.line_present = lp_q;
    assign IR_en            = ir_en_q;
    assign a2d_fault        = fault_q;
endmodule

// File: tb/tb_ir_err_calc.sv
// Self-checking bench for ir_err_calc: vector table, random vectors, corner sequences.
module tb_ir_err_calc;
    import ir_pkg::*;

    localparam int TIMEOUT = 256;
    localparam int LAT     = 3;   // A2D model: strt_cnv seen -> cnv_cmplt after LAT-1 more cycles

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic ir_en;
    logic a2d_fault;

    ir_err_calc_if bus ();

    ir_err_calc #(.FAST_SIM(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .IR_en     (ir_en),
        .a2d_fault (a2d_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cmplt7_cyc = 0;
    int withhold = -1;
    logic [11:0] vals [8];
    int strt_log [$];

    typedef struct {
        string            name;
        logic [7:0][11:0] v;
        logic [15:0]      exp_err;
        logic             exp_lp;
    } vec_t;

    vec_t tbl [7];

    // Cycle counter, advanced on the active edge so negedge readers see a stable value.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Log the channel of every strt_cnv pulse.
    initial forever begin
        @(negedge clk);
        if (bus.strt_cnv === 1'b1) strt_log.push_back(int'(bus.chnnl));
    end

    // A2D model: answers each request with vals[chnnl], unless that channel is withheld.
    initial begin
        int ch;
        bus.cnv_cmplt = 1'b0;
        bus.res       = '0;
        forever begin
            @(negedge clk);
            bus.cnv_cmplt = 1'b0;
            if (bus.strt_cnv === 1'b1 && !rst && int'(bus.chnnl) != withhold) begin
                ch = int'(bus.chnnl);
                repeat (LAT - 1) @(negedge clk);
                bus.res       = vals[ch];
                bus.cnv_cmplt = 1'b1;
                if (ch == 7) cmplt7_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: weighted sum in plain integers, then clamp; threshold on the raw sum.
    function automatic void model(input logic [7:0][11:0] v, output logic [15:0] e, output logic l);
        int w [8] = '{8, 4, 2, 1, -1, -2, -4, -8};
        int acc = 0;
        int sum = 0;
        for (int i = 0; i < 8; i++) begin
            acc += w[i] * int'(v[i]);
            sum += int'(v[i]);
        end
        if (acc > 32767) e = 16'h7FFF;
        else if (acc < -32768) e = 16'h8000;
        else e = 16'(acc);
        l = (sum > 1024);
    endfunction

    task automatic set_vals(input logic [7:0][11:0] v);
        for (int i = 0; i < 8; i++) vals[i] = v[i];
    endtask

    // Run one complete sample cycle and check result, latency, strobe width and channel order.
    task automatic run_cycle(input string name, input logic [7:0][11:0] v,
                             input logic [15:0] ee, input logic el);
        int  s0;
        int  bad;
        bit  got;
        set_vals(v);
        s0  = strt_log.size();
        got = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (bus.err_vld === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "/err_vld_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "/error"}, 32'(bus.error), 32'(ee));
            check({name, "/line_present"}, 32'(bus.line_present), 32'(el));
            check({name, "/latency"}, 32'(cyc - cmplt7_cyc), 32'd2);
            check({name, "/strt_count"}, 32'(strt_log.size() - s0), 32'd8);
            bad = 0;
            for (int k = 0; k < 8 && s0 + k < strt_log.size(); k++)
                if (strt_log[s0 + k] != k) bad++;
            check({name, "/chnnl_order_bad"}, 32'(bad), 32'd0);
            $display("cycle %s: error=%h line_present=%0d", name, bus.error, bus.line_present);
            @(negedge clk);
            check({name, "/err_vld_width"}, 32'(bus.err_vld), 32'd0);
        end
    endtask

    // Wait (bounded) for strt_cnv on a given channel.
    task automatic wait_strt(input int ch, output bit found);
        found = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (bus.strt_cnv === 1'b1 && int'(bus.chnnl) == ch) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0][11:0] rv;
        logic [15:0]      me;
        logic             ml;
        logic [15:0]      prev;
        bit               found;
        bit               gotf;
        bit               saw_vld;
        int               c0;
        int               s0;
        int               nv;

        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 8; i++) vals[i] = '0;

        tbl[0].name = "all_100";   tbl[0].v = {8{12'h100}}; tbl[0].exp_err = 16'h0000; tbl[0].exp_lp = 1'b1;
        tbl[1].name = "ch0_fff";   tbl[1].v = '0; tbl[1].v[0] = 12'hFFF;
        tbl[1].exp_err = 16'h7FF8; tbl[1].exp_lp = 1'b1;
        tbl[2].name = "ch0_3_fff"; tbl[2].v = '0;
        for (int i = 0; i < 4; i++) tbl[2].v[i] = 12'hFFF;
        tbl[2].exp_err = 16'h7FFF; tbl[2].exp_lp = 1'b1;
        tbl[3].name = "ch4_7_fff"; tbl[3].v = '0;
        for (int i = 4; i < 8; i++) tbl[3].v[i] = 12'hFFF;
        tbl[3].exp_err = 16'h8000; tbl[3].exp_lp = 1'b1;
        tbl[4].name = "all_080";   tbl[4].v = {8{12'h080}}; tbl[4].exp_err = 16'h0000; tbl[4].exp_lp = 1'b0;
        tbl[5].name = "ch7_081";   tbl[5].v = {8{12'h080}}; tbl[5].v[7] = 12'h081;
        tbl[5].exp_err = 16'hFFF8; tbl[5].exp_lp = 1'b1;
        tbl[6].name = "all_zero";  tbl[6].v = '0; tbl[6].exp_err = 16'h0000; tbl[6].exp_lp = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/error", 32'(bus.error), 32'd0);
        check("rst/err_vld", 32'(bus.err_vld), 32'd0);
        check("rst/line_present", 32'(bus.line_present), 32'd0);
        check("rst/IR_en", 32'(ir_en), 32'd0);
        check("rst/strt_cnv", 32'(bus.strt_cnv), 32'd0);
        check("rst/a2d_fault", 32'(a2d_fault), 32'd0);
        check("rst/chnnl", 32'(bus.chnnl), 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Directed vector table
        for (int t = 0; t < 7; t++)
            run_cycle(tbl[t].name, tbl[t].v, tbl[t].exp_err, tbl[t].exp_lp);

        // Random vectors against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++)
                rv[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            model(rv, me, ml);
            run_cycle($sformatf("rand%0d", r), rv, me, ml);
        end

        // Conversion timeout on ch3
        prev     = bus.error;
        withhold = 3;
        wait_strt(3, found);
        check("tmo/strt_ch3_seen", 32'(found), 32'd1);
        c0      = cyc;
        gotf    = 1'b0;
        saw_vld = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (bus.err_vld === 1'b1) saw_vld = 1'b1;
            if (a2d_fault === 1'b1) begin
                gotf = 1'b1;
                break;
            end
        end
        check("tmo/fault_seen", 32'(gotf), 32'd1);
        check("tmo/fault_latency", 32'(cyc - c0), 32'(TIMEOUT + 1));
        check("tmo/IR_en", 32'(ir_en), 32'd0);
        check("tmo/error_held", 32'(bus.error), 32'(prev));
        check("tmo/no_err_vld", 32'(saw_vld), 32'd0);
        $display("timeout: a2d_fault after %0d clocks, error=%h", cyc - c0, bus.error);
        @(negedge clk);
        check("tmo/fault_width", 32'(a2d_fault), 32'd0);
        withhold = -1;
        run_cycle("after_tmo", tbl[1].v, tbl[1].exp_err, tbl[1].exp_lp);

        // Reset pulse while waiting on ch5
        set_vals({8{12'h100}});
        wait_strt(5, found);
        check("rstwait/strt_ch5_seen", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait/error", 32'(bus.error), 32'd0);
        check("rstwait/line_present", 32'(bus.line_present), 32'd0);
        check("rstwait/err_vld", 32'(bus.err_vld), 32'd0);
        check("rstwait/IR_en", 32'(ir_en), 32'd0);
        check("rstwait/strt_cnv", 32'(bus.strt_cnv), 32'd0);
        check("rstwait/chnnl", 32'(bus.chnnl), 32'd0);
        rst = 1'b0;
        s0 = strt_log.size();
        nv = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.err_vld === 1'b1 || ir_en === 1'b1) nv++;
        end
        check("rstwait/idle_strt", 32'(strt_log.size() - s0), 32'd0);
        check("rstwait/idle_quiet", 32'(nv), 32'd0);
        $display("reset in WAIT: outputs cleared");

        // en dropped during SETTLE
        found = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (ir_en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("ensettle/IR_en_rose", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        s0 = strt_log.size();
        en = 1'b0;
        @(negedge clk);
        check("ensettle/IR_en", 32'(ir_en), 32'd0);
        repeat (200) @(negedge clk);
        check("ensettle/no_strt", 32'(strt_log.size() - s0), 32'd0);
        check("ensettle/error_held", 32'(bus.error), 32'd0);
        $display("en drop in SETTLE: IR_en=%0d strt pulses=%0d", ir_en, strt_log.size() - s0);
        en = 1'b1;
        run_cycle("after_en", tbl[1].v, tbl[1].exp_err, tbl[1].exp_lp);

        // en falls in the same clock as the ch7 cnv_cmplt
        prev = bus.error;
        set_vals({8{12'h100}});
        wait_strt(7, found);
        check("enwins/strt_ch7_seen", 32'(found), 32'd1);
        repeat (LAT - 1) @(negedge clk);
        en      = 1'b0;
        saw_vld = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.err_vld === 1'b1) saw_vld = 1'b1;
        end
        check("enwins/no_err_vld", 32'(saw_vld), 32'd0);
        check("enwins/IR_en", 32'(ir_en), 32'd0);
        check("enwins/error_held", 32'(bus.error), 32'(prev));
        $display("en vs ch7 cnv_cmplt: err_vld=%0d error=%h", saw_vld, bus.error);
        en = 1'b1;
        for (int i = 0; i < 8; i++) rv[i] = 12'($urandom);
        model(rv, me, ml);
        run_cycle("final", rv, me, ml);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
